// File: rtl/ext_pkg.sv
// Shared op encoding, lane widths and op-class helpers for the ext_pipe extender.
package ext_pkg;

    localparam int EXT_OP_W = 3;
    localparam int BYTE_W   = 8;
    localparam int HALF_W   = 16;

    typedef enum logic [EXT_OP_W-1:0] {
        OP_ZERO = 3'd0,
        OP_SIGN = 3'd1,
        OP_LUI  = 3'd2,
        OP_LW   = 3'd3,
        OP_LBU  = 3'd4,
        OP_LB   = 3'd5,
        OP_LHU  = 3'd6,
        OP_LH   = 3'd7
    } ext_op_e;

    function automatic logic is_load(ext_op_e op);
        return (op >= OP_LW);
    endfunction

    function automatic logic is_signed(ext_op_e op);
        return (op == OP_SIGN) || (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/ext_lane_sel.sv
// Stage-1 lane mux: picks immediate / byte / half / word, zero-padded, plus the
// sign bit the extend stage will replicate (0 for unsigned ops).
module ext_lane_sel
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int ADDR_W = 2
) (
    input  ext_op_e           i_op,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_lane,
    output logic              o_sign
);

    logic [ADDR_W-1:0] w_half_addr;
    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic [IMM_W-1:0]  w_imm;

    // Halfword lanes ignore addr[0]; lanes are little-endian (addr 0 = bits [7:0]).
    assign w_half_addr = i_addr & ~ADDR_W'(1);
    assign w_byte      = BYTE_W'(i_data >> {i_addr, 3'b000});
    assign w_half      = HALF_W'(i_data >> {w_half_addr, 3'b000});
    assign w_imm       = i_data[IMM_W-1:0];

    always_comb begin
        o_lane = '0;
        o_sign = 1'b0;
        unique case (i_op)
            OP_ZERO, OP_SIGN, OP_LUI: begin
                o_lane = DATA_W'(w_imm);
                o_sign = w_imm[IMM_W-1];
            end
            OP_LW: begin
                o_lane = i_data;
            end
            OP_LBU, OP_LB: begin
                o_lane = DATA_W'(w_byte);
                o_sign = w_byte[BYTE_W-1];
            end
            default: begin
                o_lane = DATA_W'(w_half);
                o_sign = w_half[HALF_W-1];
            end
        endcase
        if (!is_signed(i_op)) begin
            o_sign = 1'b0;
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// 2-stage immediate / load-data extender with valid/ready handshake and tag.
// Optional misaligned-load detection when ALIGN_CHECK_EN is defined.
module ext_pipe
    import ext_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int IMM_W  = 16,
    parameter  int TAG_W  = 5,
    localparam int ADDR_W = $clog2(DATA_W/8)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXT_OP_W-1:0] in_op,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    logic [2:1]        r_vld_pipe;
    ext_op_e           r_s1_op;
    logic [DATA_W-1:0] r_s1_lane;
    logic              r_s1_sign;
    logic [TAG_W-1:0]  r_s1_tag;
    logic [DATA_W-1:0] r_out_data;
    logic [TAG_W-1:0]  r_out_tag;

    ext_op_e           w_op;
    logic [DATA_W-1:0] w_lane;
    logic              w_sign;
    logic              w_s1_en;
    logic              w_s2_en;
    logic              w_accept;
    logic              w_s2_load;
    logic [DATA_W-1:0] w_result;

    assign w_op      = ext_op_e'(in_op);
    assign w_s2_en   = ~r_vld_pipe[2] | out_ready;
    assign w_s1_en   = ~r_vld_pipe[1] | w_s2_en;
    assign in_ready  = ~flush & w_s1_en;
    assign w_accept  = in_valid & in_ready;
    assign w_s2_load = ~flush & w_s2_en & r_vld_pipe[1];

    ext_lane_sel #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .ADDR_W (ADDR_W)
    ) u_lane_sel (
        .i_op   (w_op),
        .i_data (in_data),
        .i_addr (in_addr),
        .o_lane (w_lane),
        .o_sign (w_sign)
    );

    // Flush kills both valids but leaves data registers untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
        end else if (flush) begin
            r_vld_pipe <= '0;
        end else begin
            if (w_s1_en) r_vld_pipe[1] <= in_valid;
            if (w_s2_en) r_vld_pipe[2] <= r_vld_pipe[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_op   <= OP_ZERO;
            r_s1_lane <= '0;
            r_s1_sign <= 1'b0;
            r_s1_tag  <= '0;
        end else if (w_accept) begin
            r_s1_op   <= w_op;
            r_s1_lane <= w_lane;
            r_s1_sign <= w_sign;
            r_s1_tag  <= in_tag;
        end
    end

`ifdef ALIGN_CHECK_EN
    logic w_mis;
    logic r_s1_err;
    logic r_out_err;

    always_comb begin
        w_mis = 1'b0;
        if (is_load(w_op)) begin
            if (w_op == OP_LW) begin
                w_mis = (in_addr != '0);
            end else if (w_op == OP_LH || w_op == OP_LHU) begin
                w_mis = in_addr[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_err  <= 1'b0;
            r_out_err <= 1'b0;
        end else begin
            if (w_accept)  r_s1_err  <= w_mis;
            if (w_s2_load) r_out_err <= r_s1_err;
        end
    end

    assign out_err = r_out_err;
`else
    assign out_err = 1'b0;
`endif

    always_comb begin
        w_result = r_s1_lane;
        unique case (r_s1_op)
            OP_SIGN: w_result = {{(DATA_W-IMM_W){r_s1_sign}}, r_s1_lane[IMM_W-1:0]};
            OP_LUI:  w_result = {r_s1_lane[IMM_W-1:0], {(DATA_W-IMM_W){1'b0}}};
            OP_LB:   w_result = {{(DATA_W-BYTE_W){r_s1_sign}}, r_s1_lane[BYTE_W-1:0]};
            OP_LH:   w_result = {{(DATA_W-HALF_W){r_s1_sign}}, r_s1_lane[HALF_W-1:0]};
            default: w_result = r_s1_lane;
        endcase
`ifdef ALIGN_CHECK_EN
        // Faulting loads deliver zero data; the consumer acts on out_err.
        if (r_s1_err) begin
            w_result = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data <= '0;
            r_out_tag  <= '0;
        end else if (w_s2_load) begin
            r_out_data <= w_result;
            r_out_tag  <= r_s1_tag;
        end
    end

    assign out_valid = r_vld_pipe[2];
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: extension ops, throughput, stall, flush, reset, misalignment.
`timescale 1ns/1ps
module tb_ext_pipe;
    import ext_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_addr = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_err;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ext_pipe #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d,
                         input logic [1:0] a, input logic [4:0] t);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_addr  = a;
        in_tag   = t;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h e=%b want 0/0/0/0", out_valid, out_data, out_tag, out_err);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_sign();
        out_ready = 1'b1;
        drive(1'b1, OP_SIGN, 32'h0000_8001, 2'd3, 5'd7);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sign_in_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sign_latency1: got out_valid %b want 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8001) begin
            miscompares++;
            $display("FAIL sign_data: got v=%b d=%h want 1/ffff8001", out_valid, out_data);
        end
        vectors++;
        if (out_tag !== 5'd7) begin
            miscompares++;
            $display("FAIL sign_tag: got %0d want 7", out_tag);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL sign_drain: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, OP_LUI, 32'h5555_1234, 2'd0, 5'd1);
        tick();
        drive(1'b1, OP_ZERO, 32'hABCD_8001, 2'd0, 5'd2);
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_0000 || out_tag !== 5'd1) begin
            miscompares++;
            $display("FAIL b2b_lui: got v=%b d=%h t=%0d want 1/12340000/1", out_valid, out_data, out_tag);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_8001 || out_tag !== 5'd2) begin
            miscompares++;
            $display("FAIL b2b_zero: got v=%b d=%h t=%0d want 1/00008001/2", out_valid, out_data, out_tag);
        end
        tick();
    endtask

    task automatic test_loads();
        ext_op_e     ops [7] = '{OP_LB, OP_LBU, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LB};
        logic [31:0] dat [7] = '{32'h11F2_3344, 32'h11F2_3344, 32'h11F2_3344, 32'h11F2_3344,
                                 32'h11F2_3344, 32'h11F2_8344, 32'h11F2_3384};
        logic [1:0]  adr [7] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
        logic [31:0] exp [7] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'h0000_11F2, 32'h11F2_3344,
                                 32'h0000_0011, 32'h0000_8344, 32'hFFFF_FF84};
        out_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c < 7) drive(1'b1, ops[c], dat[c], adr[c], 5'(16 + c));
            else       drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
            tick();
            if (c >= 1) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp[c-1]) begin
                    miscompares++;
                    $display("FAIL load_%0d_data: got v=%b d=%h want 1/%h", c-1, out_valid, out_data, exp[c-1]);
                end
                vectors++;
                if (out_tag !== 5'(15 + c)) begin
                    miscompares++;
                    $display("FAIL load_%0d_tag: got %0d want %0d", c-1, out_tag, 15 + c);
                end
            end
        end
        tick();
    endtask

    task automatic test_stall();
        logic [2:0]  sop [3] = '{OP_ZERO, OP_SIGN, OP_LUI};
        logic [31:0] sdt [3] = '{32'h0000_0001, 32'h0000_7FFF, 32'h0000_ABCD};
        logic [31:0] exp [3] = '{32'h0000_0001, 32'h0000_7FFF, 32'hABCD_0000};
        int acc = 0;
        int got = 0;
        int dup = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (acc < 3) drive(1'b1, sop[acc], sdt[acc], 2'd0, 5'(10 + acc));
            else         drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid) begin
                vectors++;
                if (out_data !== exp[0] || out_tag !== 5'd10) begin
                    miscompares++;
                    $display("FAIL stall_hold: got d=%h t=%0d want %h/10", out_data, out_tag, exp[0]);
                end
            end
            tick();
        end
        vectors++;
        if (acc != 2) begin
            miscompares++;
            $display("FAIL stall_accepts: got %0d want 2", acc);
        end
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_ready: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        for (int c = 0; c < 12 && got < 3; c++) begin
            out_ready = 1'b1;
            if (acc < 3) drive(1'b1, sop[acc], sdt[acc], 2'd0, 5'(10 + acc));
            else         drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid) begin
                vectors++;
                if (out_data !== exp[got] || out_tag !== 5'(10 + got)) begin
                    miscompares++;
                    $display("FAIL drain_%0d: got d=%h t=%0d want %h/%0d", got, out_data, out_tag, exp[got], 10 + got);
                end
                got++;
            end
            tick();
        end
        vectors++;
        if (got != 3 || acc != 3) begin
            miscompares++;
            $display("FAIL drain_count: got out=%0d acc=%0d want 3/3", got, acc);
        end
        drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            if (out_valid) dup++;
            tick();
        end
        vectors++;
        if (dup != 0) begin
            miscompares++;
            $display("FAIL drain_dup: got %0d extra beats want 0", dup);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        out_ready = 1'b0;
        drive(1'b1, OP_ZERO, 32'h0000_00AA, 2'd0, 5'd3);
        tick();
        drive(1'b1, OP_ZERO, 32'h0000_00BB, 2'd0, 5'd4);
        tick();
        drive(1'b1, OP_ZERO, 32'h0000_00CC, 2'd0, 5'd5);
        flush = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 32'h0000_00AA || out_tag !== 5'd3) begin
            miscompares++;
            $display("FAIL flush_data_hold: got d=%h t=%0d want 000000aa/3", out_data, out_tag);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL flush_leak: got %0d beats want 0", seen);
        end
        drive(1'b1, OP_SIGN, 32'h0000_0123, 2'd0, 5'd6);
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_0123 || out_tag !== 5'd6) begin
            miscompares++;
            $display("FAIL flush_recover: got v=%b d=%h t=%0d want 1/00000123/6", out_valid, out_data, out_tag);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b1;
        drive(1'b1, OP_LUI, 32'h0000_BEEF, 2'd0, 5'd9);
        tick();
        drive(1'b1, OP_LW, 32'hCAFE_F00D, 2'd0, 5'd8);
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hBEEF_0000) begin
            miscompares++;
            $display("FAIL pre_reset: got v=%b d=%h want 1/beef0000", out_valid, out_data);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b d=%h t=%h e=%b want 0/0/0/0", out_valid, out_data, out_tag, out_err);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_leak: got %0d beats want 0", seen);
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  mop [3] = '{OP_LH, OP_LW, OP_LHU};
        logic [31:0] mdt [3] = '{32'h11F2_8344, 32'h11F2_3344, 32'h11F2_8344};
        logic [1:0]  mad [3] = '{2'd1, 2'd3, 2'd3};
`ifdef ALIGN_CHECK_EN
        logic [31:0] exp [3] = '{32'h0, 32'h0, 32'h0};
        logic        eer     = 1'b1;
`else
        logic [31:0] exp [3] = '{32'hFFFF_8344, 32'h11F2_3344, 32'h0000_11F2};
        logic        eer     = 1'b0;
`endif
        out_ready = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c < 3) drive(1'b1, mop[c], mdt[c], mad[c], 5'(24 + c));
            else       drive(1'b0, 3'd0, 32'h0, 2'd0, 5'd0);
            tick();
            if (c >= 1) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp[c-1] || out_tag !== 5'(23 + c)) begin
                    miscompares++;
                    $display("FAIL misalign_%0d_data: got v=%b d=%h t=%0d want 1/%h/%0d", c-1, out_valid, out_data, out_tag, exp[c-1], 23 + c);
                end
                vectors++;
                if (out_err !== eer) begin
                    miscompares++;
                    $display("FAIL misalign_%0d_err: got %b want %b", c-1, out_err, eer);
                end
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sign();
        test_back_to_back();
        test_loads();
        test_stall();
        test_flush();
        test_reset_mid();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
